// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - scans one BCD decoder across DIGITS common-anode digits, double-buffered
// Optional per-digit blink enabled by defining DISP_BLINK_EN.
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic                  lz_en,
`ifdef DISP_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start,
  output logic                  bcd_err
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]     SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE        = DIGITS'(1);

  if (DIGITS < 2 || DIGITS > 8 || BLANK_CYCLES < 1 || SCAN_DIV <= BLANK_CYCLES || BLINK_FRAMES < 1) begin : g_bad_params
    $error("display_scan_controller: illegal parameter set");
  end

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] pending, active, active_n;
  logic                pend_flag;
  logic                sup_q, sup_n;
  logic [3:0]          num_n, dig_n;
  logic [DIGITS-1:0]   anodes_n;
  logic                frame_start_n;
  logic                boundary;
  logic                show_off;

  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
    digit_at = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (IW'(k) == i) digit_at = v[4*k +: 4];
  endfunction

  // True when digit i and every digit to its left are zero (digit 0 never qualifies).
  function automatic logic upper_zero(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
    upper_zero = (i != '0);
    for (int k = 0; k < DIGITS; k++)
      if (IW'(k) >= i && v[4*k +: 4] != 4'd0) upper_zero = 1'b0;
  endfunction

  function automatic logic any_bad(input logic [4*DIGITS-1:0] v);
    any_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) any_bad = 1'b1;
  endfunction

  always_comb begin
    boundary = (state == SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
    active_n = active;
    if (boundary) begin
      if (load)           active_n = digits_in;
      else if (pend_flag) active_n = pending;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt + 1'b1;
    idx_n         = idx;
    num_n         = num;
    anodes_n      = anodes;
    frame_start_n = 1'b0;
    sup_n         = sup_q;
    dig_n         = 4'd0;
    case (state)
      BLANK: if (cnt == BLANK_LAST) begin
        state_n = SHOW;
        cnt_n   = '0;
        if (sup_q || show_off) begin
          anodes_n = '1;
          num_n    = 4'd0;
        end else begin
          anodes_n = ~(ONE << idx);
        end
      end
      SHOW: if (cnt == SHOW_LAST) begin
        state_n       = BLANK;
        cnt_n         = '0;
        idx_n         = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        anodes_n      = '1;
        frame_start_n = (idx == IDX_LAST);
        // Decoder input changes only here, a full BLANK window before the anode turns on.
        dig_n         = digit_at(active_n, idx_n);
        sup_n         = (dig_n > 4'd9) || (lz_en && upper_zero(active_n, idx_n));
        num_n         = sup_n ? 4'd0 : dig_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      num         <= 4'd0;
      anodes      <= '1;
      frame_start <= 1'b0;
      sup_q       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      num         <= num_n;
      anodes      <= anodes_n;
      frame_start <= frame_start_n;
      sup_q       <= sup_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      active    <= '0;
      pend_flag <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      active <= active_n;
      if (boundary) begin
        pend_flag <= 1'b0;
        if (load || pend_flag) bcd_err <= any_bad(active_n);
      end else if (load) begin
        pending   <= digits_in;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic          blink_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign show_off = !blink_on && blink_mask[idx];
`else
  assign show_off = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - randomized bench for display_scan_controller against a frame-level model
module tb_display_scan_controller;
  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
`ifdef DISP_BLINK_EN
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  mask_slot;
`endif
  logic [3:0]  num;
  logic [3:0]  anodes;
  logic        frame_start;
  logic        bcd_err;

  display_scan_controller #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits_in(digits_in),
    .load(load),
    .lz_en(lz_en),
`ifdef DISP_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .num(num),
    .anodes(anodes),
    .frame_start(frame_start),
    .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          c;
  logic [15:0] shown, pend;
  logic        pflag, err, lz_slot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
    end
  endtask

  function automatic logic bad_val(input logic [15:0] v);
    logic b = 1'b0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 3)));
    if ($urandom_range(0, 9) == 0) v = 16'h0;
    return v;
  endfunction

  // Expected outputs from cycle position inside the frame and the value latched for this frame.
  task automatic check_outputs();
    int s, p, f;
    logic [3:0] d, en, ea;
    logic sup, boff;
    s = (c / SCAN_DIV) % DIGITS;
    p = c % SCAN_DIV;
    f = c / FRAME;
    d = shown[4*s +: 4];
    sup = (d > 4'd9) || (lz_slot && s > 0 && (shown >> (4*s)) == 16'h0);
    boff = 1'b0;
`ifdef DISP_BLINK_EN
    boff = (p >= BLANK_CYCLES) && (((f / BLINK_FRAMES) % 2) == 1) && mask_slot[s];
`endif
    en = (sup || boff) ? 4'd0 : d;
    ea = (p < BLANK_CYCLES || sup || boff) ? 4'hF : ~(4'b0001 << s);
    chk("anodes", anodes, ea);
    chk("num", num, en);
    chk("frame_start", frame_start, (p == 0 && s == 0 && f > 0));
    chk("bcd_err", bcd_err, err);
    chk("num_range", num <= 4'd9, 1'b1);
    chk("one_anode", $countones(~anodes) <= 1, 1'b1);
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] d);
    if (c % FRAME == FRAME - 1) begin
      if (ld || pflag) begin
        shown = ld ? d : pend;
        err   = bad_val(shown);
      end
      pflag = 1'b0;
    end else if (ld) begin
      pend  = d;
      pflag = 1'b1;
    end
    if (c % SCAN_DIV == SCAN_DIV - 1) lz_slot = lz_en;
`ifdef DISP_BLINK_EN
    if (c % SCAN_DIV == BLANK_CYCLES - 1) mask_slot = blink_mask;
`endif
    c++;
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    check_outputs();
    load = ld;
    digits_in = d;
    @(posedge clk);
    model_edge(ld, d);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic wait_phase(input int m);
    for (int i = 0; i < FRAME && (c % FRAME) != m; i++) step(1'b0, 16'h0);
  endtask

  // Called at a falling edge; reset must act before the next rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_anodes", anodes, 4'hF);
    chk("rst_num", num, 4'h0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_bcd_err", bcd_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    c = 0; shown = 16'h0; pend = 16'h0; pflag = 1'b0; err = 1'b0; lz_slot = 1'b0;
`ifdef DISP_BLINK_EN
    mask_slot = 4'h0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    c = 0;
    @(negedge clk);
    do_reset();
    idle(2 * FRAME);

    lz_en = 1'b0; wait_phase(5);  step(1'b1, 16'h1234); idle(2 * FRAME);
    lz_en = 1'b1; wait_phase(10); step(1'b1, 16'h0007); idle(2 * FRAME);
    step(1'b1, 16'h0000); idle(2 * FRAME);
    lz_en = 1'b0; step(1'b1, 16'h12A4); idle(2 * FRAME);
    step(1'b1, 16'h1111); idle(2 * FRAME);

    step(1'b1, 16'h12A4); wait_phase(0); wait_phase(SCAN_DIV + 4);
    do_reset();
    idle(FRAME);

    wait_phase(3);  step(1'b1, 16'h1111);
    wait_phase(20); step(1'b1, 16'h2222);
    wait_phase(FRAME - 1); step(1'b1, 16'h3333);
    idle(2 * FRAME);

    for (int i = 0; i < 6; i++) begin
      wait_phase(FRAME - 1); step(1'b1, rand_val()); idle($urandom_range(1, 40));
    end
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 11) == 0) step(1'b1, rand_val());
      else step(1'b0, 16'h0);
    end

`ifdef DISP_BLINK_EN
    lz_en = 1'b0;
    step(1'b1, 16'h5678);
    blink_mask = 4'b0001; idle(5 * FRAME);
    for (int i = 0; i < 6; i++) begin
      blink_mask = 4'($urandom_range(0, 15));
      idle($urandom_range(10, 50));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
